// File: rtl/pin_reader_pkg.sv
// Shared constants for the pin_reader GPIO input peripheral:
// register word addresses, bus data width and debounce counter width.
package pin_reader_pkg;

  localparam int unsigned BUS_W  = 16;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CNT_W  = 16;

  localparam logic [ADDR_W-1:0] PR_STATE  = 2'd0;
  localparam logic [ADDR_W-1:0] PR_RISE   = 2'd1;
  localparam logic [ADDR_W-1:0] PR_FALL   = 2'd2;
  localparam logic [ADDR_W-1:0] PR_IRQ_EN = 2'd3;

endpackage

// File: rtl/pin_debounce.sv
// Single-pin input conditioner: two-flop synchroniser, debounce counter and
// accepted level, with single-cycle edge pulses aligned to the level update.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   pin_in      : asynchronous external pin
//   lvl         : accepted (debounced) level, registered
//   rise_c      : combinational pulse, high in the cycle whose edge sets lvl 0->1
//   fall_c      : combinational pulse, high in the cycle whose edge sets lvl 1->0
module pin_debounce
  import pin_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 48000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_in,
  output logic lvl,
  output logic rise_c,
  output logic fall_c
);

  logic             s1_q, s2_q, lvl_q;
  logic             s1_d, s2_d, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter restarts whenever the synchronised pin agrees with the accepted level.
  always_comb begin
    s1_d  = pin_in;
    s2_d  = s1_q;
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl    = lvl_q;
  assign rise_c = lvl_d & ~lvl_q;
  assign fall_c = ~lvl_d & lvl_q;

endmodule

// File: rtl/pin_reader.sv
// GPIO input peripheral: debounced pin levels, sticky rise/fall flags with
// write-1-to-clear, interrupt mask and a registered level interrupt.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   pins_in    : asynchronous external pins
//   bus_addr   : register word address (STATE, RISE, FALL, IRQ_EN)
//   bus_re     : one-cycle read strobe, data returned next cycle
//   bus_we     : one-cycle write strobe
//   bus_wdata  : write data
//   bus_rdata  : registered read data, 0 when no read is returning
//   irq        : registered level interrupt request
module pin_reader
  import pin_reader_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 48000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  pins_in,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_re,
  input  logic              bus_we,
  input  logic [BUS_W-1:0]  bus_wdata,
  output logic [BUS_W-1:0]  bus_rdata,
  output logic              irq
);

  logic [WIDTH-1:0] lvl, rise_p, fall_p;
  logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d, irq_en_q, irq_en_d;
  logic [WIDTH-1:0] rise_clr, fall_clr, wmask;
  logic [BUS_W-1:0] rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             wdata_unused;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_pin
    pin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .pin_in (pins_in[i]),
      .lvl    (lvl[i]),
      .rise_c (rise_p[i]),
      .fall_c (fall_p[i])
    );
  end

  assign wmask        = bus_wdata[WIDTH-1:0];
  assign wdata_unused = ^bus_wdata;

  // Register writes, flag update (a new edge beats a same-cycle clear), read mux, irq.
  always_comb begin
    rise_clr = '0;
    fall_clr = '0;
    irq_en_d = irq_en_q;
    rdata_d  = '0;
    if (bus_we) begin
      case (bus_addr)
        PR_RISE:   rise_clr = wmask;
        PR_FALL:   fall_clr = wmask;
        PR_IRQ_EN: irq_en_d = wmask;
        default:   ;
      endcase
    end
    rise_d = (rise_q & ~rise_clr) | rise_p;
    fall_d = (fall_q & ~fall_clr) | fall_p;
    // Read sees pre-write register contents.
    if (bus_re) begin
      case (bus_addr)
        PR_STATE:  rdata_d = BUS_W'(lvl);
        PR_RISE:   rdata_d = BUS_W'(rise_q);
        PR_FALL:   rdata_d = BUS_W'(fall_q);
        PR_IRQ_EN: rdata_d = BUS_W'(irq_en_q);
        default:   rdata_d = '0;
      endcase
    end
    irq_d = |((rise_q | fall_q) & irq_en_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q   <= '0;
      fall_q   <= '0;
      irq_en_q <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_pin_reader.sv
// Directed bench for pin_reader with WIDTH=4, DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_pin_reader;
  import pin_reader_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEB   = 4;

  logic              clk;
  logic              rst;
  logic [WIDTH-1:0]  pins_in;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_re;
  logic              bus_we;
  logic [BUS_W-1:0]  bus_wdata;
  logic [BUS_W-1:0]  bus_rdata;
  logic              irq;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [BUS_W-1:0] rd;

  pin_reader #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pins_in  (pins_in),
    .bus_addr (bus_addr),
    .bus_re   (bus_re),
    .bus_we   (bus_we),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_rd(input logic [ADDR_W-1:0] a, output logic [BUS_W-1:0] d);
    bus_addr = a;
    bus_re   = 1'b1;
    tick();
    bus_re   = 1'b0;
    d        = bus_rdata;
  endtask

  task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [BUS_W-1:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    tick();
    bus_we    = 1'b0;
    bus_wdata = '0;
  endtask

  initial begin
    rst = 1'b1; pins_in = '0; bus_addr = '0; bus_re = 1'b0; bus_we = 1'b0; bus_wdata = '0;
    ticks(3);
    rst = 1'b0;
    tick();

    // Reset state
    bus_rd(PR_STATE, rd);  chk("reset_state", rd, 16'h0000);
    bus_rd(PR_RISE, rd);   chk("reset_rise", rd, 16'h0000);
    bus_rd(PR_FALL, rd);   chk("reset_fall", rd, 16'h0000);
    bus_rd(PR_IRQ_EN, rd); chk("reset_irq_en", rd, 16'h0000);
    chk("reset_irq", 16'(irq), 16'h0000);
    tick();
    chk("idle_rdata", bus_rdata, 16'h0000);

    // Clean press on pin0: lvl updates at edge k+5
    pins_in[0] = 1'b1;
    ticks(5);                      // edges k..k+4
    bus_rd(PR_STATE, rd); chk("press_state_k5_old", rd, 16'h0000);
    bus_rd(PR_STATE, rd); chk("press_state", rd, 16'h0001);
    bus_rd(PR_RISE, rd);  chk("press_rise", rd, 16'h0001);

    // Glitch on pin1: high for 3 cycles only
    pins_in[1] = 1'b1;
    ticks(3);
    pins_in[1] = 1'b0;
    ticks(8);
    bus_rd(PR_STATE, rd); chk("glitch_state", rd, 16'h0001);
    bus_rd(PR_RISE, rd);  chk("glitch_rise", rd, 16'h0001);

    // Release and IRQ
    bus_wr(PR_RISE, 16'h0001);
    bus_rd(PR_RISE, rd);  chk("rise_w1c", rd, 16'h0000);
    bus_wr(PR_IRQ_EN, 16'h0001);
    ticks(2);
    chk("irq_idle", 16'(irq), 16'h0000);
    pins_in[0] = 1'b0;
    ticks(6);                      // through edge k+5: FALL set
    chk("irq_before", 16'(irq), 16'h0000);
    tick();
    chk("irq_set", 16'(irq), 16'h0001);
    bus_rd(PR_FALL, rd);  chk("release_fall", rd, 16'h0001);
    bus_rd(PR_STATE, rd); chk("release_state", rd, 16'h0000);
    bus_wr(PR_FALL, 16'h0001);
    chk("irq_hold_after_clr", 16'(irq), 16'h0001);
    bus_wr(PR_RISE, 16'h0001);
    chk("irq_cleared", 16'(irq), 16'h0000);
    bus_rd(PR_FALL, rd);  chk("fall_w1c", rd, 16'h0000);

    // Set/clear collision on pin2, with a simultaneous read of the pre-write value
    pins_in[2] = 1'b1;
    ticks(5);                      // edges k..k+4
    bus_addr  = PR_RISE;
    bus_wdata = 16'h0004;
    bus_we    = 1'b1;
    bus_re    = 1'b1;
    tick();                        // edge k+5: lvl rises, clear collides
    bus_we = 1'b0; bus_re = 1'b0; bus_wdata = '0;
    chk("rw_pre_value", bus_rdata, 16'h0000);
    bus_rd(PR_RISE, rd);  chk("collision_rise", rd, 16'h0004);
    bus_wr(PR_RISE, 16'h0004);
    bus_rd(PR_RISE, rd);  chk("rise2_w1c", rd, 16'h0000);

    // Back-to-back reads
    bus_addr = PR_STATE;
    bus_re   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("b2b_state_%0d", i), bus_rdata, 16'h0004);
    end
    bus_addr = PR_IRQ_EN;
    tick();
    chk("b2b_irq_en", bus_rdata, 16'h0001);
    bus_re = 1'b0;
    tick();
    chk("b2b_idle", bus_rdata, 16'h0000);

    // Width masking and STATE write ignore
    bus_wr(PR_IRQ_EN, 16'hFFFF);
    bus_rd(PR_IRQ_EN, rd); chk("irq_en_mask", rd, 16'h000F);
    bus_wr(PR_STATE, 16'hFFFF);
    bus_rd(PR_STATE, rd);  chk("state_ro", rd, 16'h0004);
    chk("irq_no_flags", 16'(irq), 16'h0000);

    // Pin3 rise raises irq under full mask, then reset drops everything
    pins_in[3] = 1'b1;
    ticks(7);
    chk("irq_pin3", 16'(irq), 16'h0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_irq", 16'(irq), 16'h0000);
    bus_rd(PR_STATE, rd);  chk("rst_state", rd, 16'h0000);
    bus_rd(PR_IRQ_EN, rd); chk("rst_irq_en", rd, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
